// File: rtl/phy_regfile_read_stage_if.sv
// Dispatch, CDB broadcast and issue signals of the physical-register read stage.
// The slave modport is the stage's view; the master modport is the surrounding pipeline's.
interface phy_regfile_read_stage_if #(
  parameter int unsigned NUM_PHY_REGS = 64,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_CDB      = 2,
  parameter int unsigned PAYLOAD_W    = 96
);
  localparam int unsigned PREG_W = $clog2(NUM_PHY_REGS);

  logic                        in_valid;
  logic                        in_ready;
  logic [PREG_W-1:0]           in_src1_reg;
  logic [PREG_W-1:0]           in_src2_reg;
  logic [PAYLOAD_W-1:0]        in_payload;

  logic [NUM_CDB-1:0]          cdb_valid;
  logic [NUM_CDB*PREG_W-1:0]   cdb_reg;
  logic [NUM_CDB*DATA_W-1:0]   cdb_val;

  logic                        out_valid;
  logic                        out_ready;
  logic [PREG_W-1:0]           out_src1_reg;
  logic [PREG_W-1:0]           out_src2_reg;
  logic [DATA_W-1:0]           out_src1_val;
  logic [DATA_W-1:0]           out_src2_val;
  logic [PAYLOAD_W-1:0]        out_payload;

  modport master (
    output in_valid, in_src1_reg, in_src2_reg, in_payload,
    output cdb_valid, cdb_reg, cdb_val,
    output out_ready,
    input  in_ready,
    input  out_valid, out_src1_reg, out_src2_reg, out_src1_val, out_src2_val, out_payload
  );

  modport slave (
    input  in_valid, in_src1_reg, in_src2_reg, in_payload,
    input  cdb_valid, cdb_reg, cdb_val,
    input  out_ready,
    output in_ready,
    output out_valid, out_src1_reg, out_src2_reg, out_src1_val, out_src2_val, out_payload
  );
endinterface

// File: rtl/phy_regfile_read_stage.sv
// Physical register file plus read stage: skid FIFO for dispatched ops, CDB bypass on read,
// and CDB refresh of operands held in the output register under backpressure.
module phy_regfile_read_stage #(
  parameter int unsigned NUM_PHY_REGS = 64,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_CDB      = 2,
  parameter int unsigned SKID_DEPTH   = 4,
  parameter int unsigned PAYLOAD_W    = 96,
  parameter logic [PAYLOAD_W-1:0] PAYLOAD_RESET = '0
) (
  input logic                      clk,
  input logic                      reset,
  input logic                      flush,
  phy_regfile_read_stage_if.slave  bus
);
  localparam int unsigned PREG_W = $clog2(NUM_PHY_REGS);
  localparam int unsigned PTR_W  = $clog2(SKID_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0]    rf_q [NUM_PHY_REGS];

  logic [PREG_W-1:0]    fifo_src1_q    [SKID_DEPTH];
  logic [PREG_W-1:0]    fifo_src2_q    [SKID_DEPTH];
  logic [PAYLOAD_W-1:0] fifo_payload_q [SKID_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 in_ready_q, in_ready_d;

  logic                 out_valid_q;
  logic [PREG_W-1:0]    out_src1_q, out_src2_q;
  logic [DATA_W-1:0]    out_val1_q, out_val2_q;
  logic [PAYLOAD_W-1:0] out_payload_q;

  logic                 accept, out_free, fifo_empty, load, enq, deq;
  logic [PREG_W-1:0]    head_src1, head_src2;
  logic [PAYLOAD_W-1:0] head_payload;
  logic [DATA_W-1:0]    head_val1, head_val2, hold_val1, hold_val2;

  // Register read with same-cycle CDB bypass; later ports override earlier ones.
  function automatic logic [DATA_W-1:0] bypass_read(
    input logic [PREG_W-1:0]         r,
    input logic [DATA_W-1:0]         rf_val,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*PREG_W-1:0] cr,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic [DATA_W-1:0] v;
    v = rf_val;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cv[k] && (cr[k*PREG_W +: PREG_W] == r)) v = cd[k*DATA_W +: DATA_W];
    end
    if (r == '0) v = '0;
    return v;
  endfunction

  // Refresh of a held operand; only nonzero source regs are tracked.
  function automatic logic [DATA_W-1:0] refresh(
    input logic [PREG_W-1:0]         r,
    input logic [DATA_W-1:0]         cur,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*PREG_W-1:0] cr,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic [DATA_W-1:0] v;
    v = cur;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cv[k] && (r != '0) && (cr[k*PREG_W +: PREG_W] == r)) v = cd[k*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  always_comb begin
    accept     = bus.in_valid & in_ready_q;
    out_free   = ~out_valid_q | bus.out_ready;
    fifo_empty = (count_q == '0);
    load       = out_free & (~fifo_empty | accept);
    deq        = out_free & ~fifo_empty;
    enq        = accept & (~fifo_empty | ~out_free);

    head_src1    = fifo_empty ? bus.in_src1_reg : fifo_src1_q[rd_ptr_q];
    head_src2    = fifo_empty ? bus.in_src2_reg : fifo_src2_q[rd_ptr_q];
    head_payload = fifo_empty ? bus.in_payload  : fifo_payload_q[rd_ptr_q];
    head_val1    = bypass_read(head_src1, rf_q[head_src1], bus.cdb_valid, bus.cdb_reg,
                               bus.cdb_val);
    head_val2    = bypass_read(head_src2, rf_q[head_src2], bus.cdb_valid, bus.cdb_reg,
                               bus.cdb_val);
    hold_val1    = refresh(out_src1_q, out_val1_q, bus.cdb_valid, bus.cdb_reg, bus.cdb_val);
    hold_val2    = refresh(out_src2_q, out_val2_q, bus.cdb_valid, bus.cdb_reg, bus.cdb_val);

    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d < CNT_W'(SKID_DEPTH));
  end

  // Regfile keeps taking CDB writes during flush; reset alone clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHY_REGS; i++) rf_q[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (bus.cdb_valid[k] && (bus.cdb_reg[k*PREG_W +: PREG_W] != '0)) begin
          rf_q[bus.cdb_reg[k*PREG_W +: PREG_W]] <= bus.cdb_val[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        fifo_src1_q[i]    <= '0;
        fifo_src2_q[i]    <= '0;
        fifo_payload_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_src1_q    <= '0;
      out_src2_q    <= '0;
      out_val1_q    <= '0;
      out_val2_q    <= '0;
      out_payload_q <= PAYLOAD_RESET;
    end else if (flush) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (enq) begin
        fifo_src1_q[wr_ptr_q]    <= bus.in_src1_reg;
        fifo_src2_q[wr_ptr_q]    <= bus.in_src2_reg;
        fifo_payload_q[wr_ptr_q] <= bus.in_payload;
        wr_ptr_q                 <= wr_ptr_q + PTR_W'(1);
      end
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      in_ready_q <= in_ready_d;

      if (load) begin
        out_valid_q   <= 1'b1;
        out_src1_q    <= head_src1;
        out_src2_q    <= head_src2;
        out_val1_q    <= head_val1;
        out_val2_q    <= head_val2;
        out_payload_q <= head_payload;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end else begin
        out_val1_q <= hold_val1;
        out_val2_q <= hold_val2;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_src1_reg = out_src1_q;
  assign bus.out_src2_reg = out_src2_q;
  assign bus.out_src1_val = out_val1_q;
  assign bus.out_src2_val = out_val2_q;
  assign bus.out_payload  = out_payload_q;
endmodule

// File: tb/tb_phy_regfile_read_stage.sv
// Scoreboard bench: expected in-flight ops queue plus a behavioural register file; the monitor
// checks the presented op, its operand values, out_valid and in_ready every cycle.
module tb_phy_regfile_read_stage;
  localparam int unsigned NPR = 64;
  localparam int unsigned DW  = 32;
  localparam int unsigned NC  = 2;
  localparam int unsigned SD  = 4;
  localparam int unsigned PW  = 96;
  localparam int unsigned PRW = $clog2(NPR);
  localparam logic [PW-1:0] PRST = 96'h5a5a_0001_c3c3_0002_9696_0003;

  typedef struct packed {
    logic [PRW-1:0] s1;
    logic [PRW-1:0] s2;
    logic [PW-1:0]  pl;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  phy_regfile_read_stage_if #(.NUM_PHY_REGS(NPR), .DATA_W(DW), .NUM_CDB(NC), .PAYLOAD_W(PW))
    bus ();

  phy_regfile_read_stage #(
    .NUM_PHY_REGS (NPR),
    .DATA_W       (DW),
    .NUM_CDB      (NC),
    .SKID_DEPTH   (SD),
    .PAYLOAD_W    (PW),
    .PAYLOAD_RESET(PRST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_rf [NPR];
  ent_t          q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural register state: last write per edge, highest port wins, reg 0 stays zero.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPR; i++) m_rf[i] <= '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (bus.cdb_valid[k] && bus.cdb_reg[k*PRW +: PRW] != '0)
          m_rf[bus.cdb_reg[k*PRW +: PRW]] <= bus.cdb_val[k*DW +: DW];
      end
    end
  end

  // Any op at the head must show the current register values, whether just loaded or held.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      check("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
      check("in_ready", 128'(bus.in_ready), 128'(q.size() <= SD));
      if (q.size() > 0 && bus.out_valid) begin
        check("out_src1_reg", 128'(bus.out_src1_reg), 128'(q[0].s1));
        check("out_src2_reg", 128'(bus.out_src2_reg), 128'(q[0].s2));
        check("out_payload", 128'(bus.out_payload), 128'(q[0].pl));
        check("out_src1_val", 128'(bus.out_src1_val), 128'(m_rf[q[0].s1]));
        check("out_src2_val", 128'(bus.out_src2_val), 128'(m_rf[q[0].s2]));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready)
        q.push_back('{s1: bus.in_src1_reg, s2: bus.in_src2_reg, pl: bus.in_payload});
    end
  end

  task automatic cyc(input logic iv, input logic [PRW-1:0] s1, input logic [PRW-1:0] s2,
                     input logic ordy, input logic [NC-1:0] cv,
                     input logic [NC*PRW-1:0] cr, input logic [NC*DW-1:0] cd,
                     input logic fl);
    bus.in_valid    = iv;
    bus.in_src1_reg = s1;
    bus.in_src2_reg = s2;
    bus.in_payload  = {$urandom(), $urandom(), $urandom()};
    bus.out_ready   = ordy;
    bus.cdb_valid   = cv;
    bus.cdb_reg     = cr;
    bus.cdb_val     = cd;
    flush           = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, '0, ordy, '0, '0, '0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_payload", 128'(bus.out_payload), 128'(PRST));
    check("rst_src1_reg", 128'(bus.out_src1_reg), 128'(0));
    check("rst_src2_val", 128'(bus.out_src2_val), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_src1_reg = '0; bus.in_src2_reg = '0; bus.in_payload = '0;
    bus.out_ready = 1'b1; bus.cdb_valid = '0; bus.cdb_reg = '0; bus.cdb_val = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs();

    // Preload reg5, then read it with src2 = 0.
    cyc(1'b0, '0, '0, 1'b1, 2'b01, {PRW'(0), PRW'(5)}, {DW'(0), DW'(32'h11)}, 1'b0);
    cyc(1'b1, PRW'(5), PRW'(0), 1'b1, '0, '0, '0, 1'b0);
    idle(1'b1);

    // Same-cycle bypass, bypass of reg 0, and two ports racing for one reg.
    cyc(1'b1, PRW'(7), PRW'(5), 1'b1, 2'b10, {PRW'(7), PRW'(0)}, {DW'(32'habcd), DW'(0)}, 1'b0);
    cyc(1'b1, PRW'(0), PRW'(7), 1'b1, 2'b10, {PRW'(0), PRW'(0)}, {DW'(32'hbeef), DW'(0)}, 1'b0);
    cyc(1'b1, PRW'(9), PRW'(9), 1'b1, 2'b11, {PRW'(9), PRW'(9)}, {DW'(2), DW'(1)}, 1'b0);
    idle(1'b1);

    // Backpressure: fill output + FIFO, one extra offer while full, then drain.
    repeat (6) cyc(1'b1, PRW'($urandom_range(0, 9)), PRW'($urandom_range(0, 9)), 1'b0,
                   '0, '0, '0, 1'b0);
    repeat (7) idle(1'b1);

    // Hold refresh of src2 = 9 while the consumer stalls.
    cyc(1'b1, PRW'(3), PRW'(9), 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 2'b01, {PRW'(0), PRW'(9)}, {DW'(0), DW'(32'h55)}, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Flush with a full FIFO and a new offer in the flush cycle.
    repeat (5) cyc(1'b1, PRW'($urandom_range(0, 9)), PRW'(5), 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b1, PRW'(4), PRW'(4), 1'b0, 2'b01, {PRW'(0), PRW'(4)}, {DW'(0), DW'(32'h44)}, 1'b1);
    repeat (4) idle(1'b1);
    cyc(1'b1, PRW'(4), PRW'(0), 1'b1, '0, '0, '0, 1'b0);
    idle(1'b1);

    // Reset mid-operation, then reg 5 must read back as zero.
    repeat (3) cyc(1'b1, PRW'(5), PRW'(7), 1'b0, '0, '0, '0, 1'b0);
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
    check_reset_outputs();
    cyc(1'b1, PRW'(5), PRW'(7), 1'b1, '0, '0, '0, 1'b0);
    idle(1'b1);

    // Random traffic over a small reg set so bypass and refresh hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 3) != 0,
          PRW'($urandom_range(0, 7)), PRW'($urandom_range(0, 7)),
          $urandom_range(0, 9) < 6,
          NC'($urandom_range(0, 3)),
          {PRW'($urandom_range(0, 7)), PRW'($urandom_range(0, 7))},
          {DW'($urandom()), DW'($urandom())},
          $urandom_range(0, 63) == 0);
    end
    reset = 1'b0;

    repeat (20) idle(1'b1);
    @(negedge clk);
    check("drained", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
